// File: rtl/adc_spi_capture.sv
// -----------------------------------------------------------------------------
// adc_spi_capture
//
// Purpose : Runs conversions on a serial ADC at a programmable rate, shifts
//           each result in MSB-first and buffers samples in a small
//           first-word-fall-through FIFO that the register bank pops.
//
// Ports   : ACLK, ARESET          - clock, synchronous active-high reset
//           enable                - run conversions while high
//           sample_period[15:0]   - start-to-start interval (0 -> minimum)
//           clear_ovf             - pulse, clears the sticky overflow flag
//           adc_cnv, adc_sclk     - conversion start / serial clock to ADC
//           adc_sdo               - serial data from ADC
//           rd_en                 - pop request (ignored when FIFO empty)
//           rd_data, rd_valid     - FIFO head and not-empty flag
//           fifo_count            - FIFO occupancy
//           overflow              - sticky, a sample was dropped
//
// Build option: define ADC_CAPTURE_TEST_PATTERN_EN to push an internal ramp
//           counter instead of the captured ADC word (ADC pins keep running).
// -----------------------------------------------------------------------------
module adc_spi_capture #(
   parameter int DATA_WIDTH  = 16,
   parameter int CLK_DIV     = 4,
   parameter int CONV_CYCLES = 50,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic                          enable,
   input  logic [15:0]                   sample_period,
   input  logic                          clear_ovf,
   output logic                          adc_cnv,
   output logic                          adc_sclk,
   input  logic                          adc_sdo,
   input  logic                          rd_en,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int CONV_W = $clog2(CONV_CYCLES + 1);
   localparam int DIV_W  = $clog2(CLK_DIV + 1);
   localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
   localparam int T_MIN  = CONV_CYCLES + 2 * CLK_DIV * DATA_WIDTH + 1;
   localparam logic [15:0] T_MIN16 = 16'(T_MIN);

   typedef enum logic [2:0] {IDLE, CONVERT, ACQUIRE, STORE, WAIT} state_t;

   state_t                  r_state;
   logic                    r_cnv;
   logic                    r_sclk;
   logic [CONV_W-1:0]       r_conv_cnt;
   logic [DIV_W-1:0]        r_div_cnt;
   logic [EDGE_W-1:0]       r_edge_cnt;
   logic [15:0]             r_period_cnt;
   logic [DATA_WIDTH-1:0]   r_shift;

   logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;
   logic [DATA_WIDTH-1:0]   r_rd_data;
   logic                    r_valid;
   logic                    r_overflow;

   logic [15:0]             w_eff_period;
   logic [DATA_WIDTH-1:0]   w_push_data;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_accept;
   logic                    w_drop;
   logic [CNT_W-1:0]        w_count_next;
   logic [PTR_W-1:0]        w_rd_ptr_next;
   logic [DATA_WIDTH-1:0]   w_head_next;

   // Anything below the minimum (including 0) runs at the fastest legal rate.
   assign w_eff_period = (sample_period < T_MIN16) ? T_MIN16 : sample_period;

   // ---------------------------------------------------------------- FSM ----
   // The period counter is loaded with period-1 on entry to CONVERT and counts
   // down every cycle, so it reads 0 in the last cycle of the interval; the
   // next CONVERT is then entered exactly one period after the previous one.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state      <= IDLE;
         r_cnv        <= 1'b0;
         r_sclk       <= 1'b0;
         r_conv_cnt   <= '0;
         r_div_cnt    <= '0;
         r_edge_cnt   <= '0;
         r_period_cnt <= '0;
         r_shift      <= '0;
      end else begin
         if (r_period_cnt != 16'd0)
            r_period_cnt <= r_period_cnt - 16'd1;

         case (r_state)
            IDLE: begin
               if (enable) begin
                  r_state      <= CONVERT;
                  r_cnv        <= 1'b1;
                  r_conv_cnt   <= '0;
                  r_period_cnt <= w_eff_period - 16'd1;
               end
            end

            CONVERT: begin
               if (r_conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
                  r_state    <= ACQUIRE;
                  r_cnv      <= 1'b0;
                  r_sclk     <= 1'b0;
                  r_div_cnt  <= '0;
                  r_edge_cnt <= '0;
               end else begin
                  r_conv_cnt <= r_conv_cnt + 1'b1;
               end
            end

            ACQUIRE: begin
               if (r_div_cnt == DIV_W'(CLK_DIV - 1)) begin
                  r_div_cnt <= '0;
                  r_sclk    <= ~r_sclk;
                  // Data is captured on the edge that drives sclk high.
                  if (!r_sclk)
                     r_shift <= {r_shift[DATA_WIDTH-2:0], adc_sdo};
                  if (r_edge_cnt == EDGE_W'(2 * DATA_WIDTH - 1))
                     r_state <= STORE;
                  else
                     r_edge_cnt <= r_edge_cnt + 1'b1;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end

            STORE: begin
               // At the minimum period the counter is already exhausted here,
               // so the next conversion starts without passing through WAIT.
               if (!enable) begin
                  r_state <= IDLE;
               end else if (r_period_cnt == 16'd0) begin
                  r_state      <= CONVERT;
                  r_cnv        <= 1'b1;
                  r_conv_cnt   <= '0;
                  r_period_cnt <= w_eff_period - 16'd1;
               end else begin
                  r_state <= WAIT;
               end
            end

            WAIT: begin
               if (r_period_cnt == 16'd0) begin
                  if (enable) begin
                     r_state      <= CONVERT;
                     r_cnv        <= 1'b1;
                     r_conv_cnt   <= '0;
                     r_period_cnt <= w_eff_period - 16'd1;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
   // Ramp advances on every STORE, whether or not the FIFO accepts it.
   logic [DATA_WIDTH-1:0] r_ramp;

   always_ff @(posedge ACLK) begin
      if (ARESET)
         r_ramp <= '0;
      else if (w_push)
         r_ramp <= r_ramp + 1'b1;
   end

   assign w_push_data = r_ramp;
`else
   assign w_push_data = r_shift;
`endif

   // --------------------------------------------------------------- FIFO ----
   assign w_push        = (r_state == STORE);
   assign w_pop         = rd_en && (r_count != '0);
   assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_accept      = w_push && (!w_full || w_pop);
   assign w_drop        = w_push && !w_accept;
   assign w_count_next  = r_count + {{(CNT_W-1){1'b0}}, w_accept}
                                  - {{(CNT_W-1){1'b0}}, w_pop};
   assign w_rd_ptr_next = r_rd_ptr + {{(PTR_W-1){1'b0}}, w_pop};

   // The next head is the word being written this cycle when it lands exactly
   // at the new read pointer (FIFO empty or draining to one entry).
   assign w_head_next = (w_accept && (w_rd_ptr_next == r_wr_ptr)) ?
                        w_push_data : r_mem[w_rd_ptr_next];

   always_ff @(posedge ACLK) begin
      if (w_accept)
         r_mem[r_wr_ptr] <= w_push_data;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_data  <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         r_rd_ptr <= w_rd_ptr_next;
         r_count  <= w_count_next;
         r_valid  <= (w_count_next != '0);
         // When the FIFO drains, the last popped word stays on rd_data.
         if (w_count_next != '0)
            r_rd_data <= w_head_next;
         // A new drop beats a simultaneous clear.
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clear_ovf)
            r_overflow <= 1'b0;
      end
   end

   assign adc_cnv    = r_cnv;
   assign adc_sclk   = r_sclk;
   assign rd_data    = r_rd_data;
   assign rd_valid   = r_valid;
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_adc_spi_capture.sv
`timescale 1ns/1ps
module tb_adc_spi_capture;

   localparam int DW = 16;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic          enable;
   logic [15:0]   sample_period;
   logic          clear_ovf;
   logic          adc_cnv;
   logic          adc_sclk;
   logic          adc_sdo;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [3:0]    fifo_count;
   logic          overflow;

   adc_spi_capture dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .enable        (enable),
      .sample_period (sample_period),
      .clear_ovf     (clear_ovf),
      .adc_cnv       (adc_cnv),
      .adc_sclk      (adc_sclk),
      .adc_sdo       (adc_sdo),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .fifo_count    (fifo_count),
      .overflow      (overflow)
   );

   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q[$];     // scoreboard: expected FIFO output order
   logic [DW-1:0] model_q[$];   // words the ADC model will send
   int            cnv_rise[$];
   int            cnv_fall[$];
   int            sclk_rises = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   function automatic int cnv_at(input int i);
      return (cnv_rise.size() > i) ? cnv_rise[i] : -1000000;
   endfunction

   // ADC model + edge recorder + scoreboard monitor, all on the falling edge.
   task automatic monitor();
      logic          pc, ps;
      logic [DW-1:0] word;
      int            bidx;
      pc = 1'b0; ps = 1'b0; word = '1; bidx = 0; adc_sdo = 1'b1;
      forever begin
         @(negedge ACLK);
         if (!ARESET) begin
            if (!pc && adc_cnv) cnv_rise.push_back(cyc);
            if (pc && !adc_cnv) begin
               cnv_fall.push_back(cyc);
               word    = (model_q.size() != 0) ? model_q.pop_front() : 16'hFFFF;
               bidx    = DW - 1;
               adc_sdo = word[bidx];
            end
            if (!ps && adc_sclk) sclk_rises++;
            if (ps && !adc_sclk && bidx > 0) begin
               bidx--;
               adc_sdo = word[bidx];
            end
            if (rd_en && rd_valid) begin
               check("pop_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) check("pop_data", rd_data, exp_q.pop_front());
            end
         end
         pc = adc_cnv;
         ps = adc_sclk;
      end
   endtask

   task automatic wait_rises(input int n, input int budget, input string name);
      int t = 0;
      while (cnv_rise.size() < n && t < budget) begin step(); t++; end
      check({name, "_cnv_timeout"}, 32'(cnv_rise.size() >= n), 1);
   endtask

   task automatic wait_count(input int n, input int budget, input string name);
      int t = 0;
      while (int'(fifo_count) != n && t < budget) begin step(); t++; end
      check({name, "_count"}, fifo_count, n);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) step();
   endtask

   task automatic pop_all();
      int t = 0;
      while (rd_valid && t < 20) begin rd_en = 1'b1; step(); t++; end
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      ARESET = 1'b1;
      step(3);
      check("rst_cnv", adc_cnv, 0);
      check("rst_sclk", adc_sclk, 0);
      check("rst_valid", rd_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ovf", overflow, 0);
      check("rst_data", rd_data, 0);
      ARESET = 1'b0;
      step(2);
   endtask

   initial begin
      int base, fb, en_cyc, v_cyc, s0, s1, t, r9, f;
      ARESET = 1'b1; enable = 1'b0; sample_period = 16'd0;
      clear_ovf = 1'b0; rd_en = 1'b0;
      fork
         monitor();
      join_none
      do_reset();

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
      // sdo idles at 1 in the model; the ramp must replace it.
      for (int i = 0; i < 4; i++) exp_q.push_back(DW'(i));
      base = cnv_rise.size();
      enable = 1'b1;
      wait_rises(base + 4, 800, "tp");
      enable = 1'b0;
      wait_count(4, 400, "tp");
      pop_all();
      check("tp_sb_empty", exp_q.size(), 0);
`else
      // ---- basic capture at minimum period
      model_q.push_back(16'hA5C3); exp_q.push_back(16'hA5C3);
      model_q.push_back(16'h5A3C); exp_q.push_back(16'h5A3C);
      base = cnv_rise.size(); fb = cnv_fall.size();
      s0 = sclk_rises; en_cyc = cyc;
      enable = 1'b1;
      t = 0;
      while (!rd_valid && t < 400) begin step(); t++; end
      v_cyc = cyc; s1 = sclk_rises;
      check("enable_to_cnv", cnv_at(base) - en_cyc, 1);
      check("cnv_width", ((cnv_fall.size() > fb) ? cnv_fall[fb] : 0) - cnv_at(base), 50);
      check("sclk_rises", s1 - s0, 16);
      check("valid_latency", v_cyc - cnv_at(base), 179);
      check("first_data", rd_data, 16'hA5C3);
      check("first_count", fifo_count, 1);
      step(2);
      check("period_tmin", cnv_at(base + 1) - cnv_at(base), 179);
      enable = 1'b0;
      wait_count(2, 400, "basic");
      step(400);
      check("basic_no_extra_cnv", cnv_rise.size() - base, 2);
      pop_all();
      check("basic_sb_empty", exp_q.size(), 0);

      // ---- programmed rate
      sample_period = 16'd300;
      for (int i = 1; i <= 3; i++) begin model_q.push_back(DW'(i)); exp_q.push_back(DW'(i)); end
      base = cnv_rise.size();
      enable = 1'b1;
      wait_rises(base + 3, 1000, "rate");
      enable = 1'b0;
      wait_count(3, 400, "rate");
      check("rate_gap1", cnv_at(base + 1) - cnv_at(base), 300);
      check("rate_gap2", cnv_at(base + 2) - cnv_at(base + 1), 300);
      pop_all();
      check("empty_valid", rd_valid, 0);
      check("empty_hold", rd_data, 16'h0003);
      rd_en = 1'b1; step(2); rd_en = 1'b0;
      check("empty_pop_count", fifo_count, 0);
      check("empty_pop_hold", rd_data, 16'h0003);

      // ---- overflow: 10 samples, no pops
      sample_period = 16'd0;
      for (int i = 0; i < 10; i++) begin
         model_q.push_back(DW'(16'h0100 + i));
         if (i < 8) exp_q.push_back(DW'(16'h0100 + i));
      end
      base = cnv_rise.size();
      enable = 1'b1;
      wait_rises(base + 9, 2500, "ovf9");
      r9 = cnv_at(base + 8);
      wait_cyc(r9 + 178);            // STORE cycle of the 9th (dropped) sample
      clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
      check("ovf_beats_clear", overflow, 1);
      check("ovf_full_count", fifo_count, 8);
      wait_rises(base + 10, 400, "ovf10");
      enable = 1'b0;
      step(250);
      check("ovf_count", fifo_count, 8);
      check("ovf_flag", overflow, 1);
      clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
      check("ovf_cleared", overflow, 0);
      pop_all();
      check("ovf_sb_empty", exp_q.size(), 0);

      // ---- push into full FIFO with a simultaneous pop
      for (int i = 0; i < 9; i++) begin
         model_q.push_back(DW'(16'h0200 + i));
         exp_q.push_back(DW'(16'h0200 + i));
      end
      base = cnv_rise.size();
      enable = 1'b1;
      wait_rises(base + 9, 2500, "pp");
      enable = 1'b0;
      r9 = cnv_at(base + 8);
      wait_cyc(r9 + 178);
      check("pp_full_before", fifo_count, 8);
      rd_en = 1'b1; step(); rd_en = 1'b0;
      check("pp_count", fifo_count, 8);
      check("pp_no_ovf", overflow, 0);
      step(5);
      pop_all();
      check("pp_sb_empty", exp_q.size(), 0);

      // ---- enable dropped during ACQUIRE
      model_q.push_back(16'h1234); exp_q.push_back(16'h1234);
      base = cnv_rise.size(); fb = cnv_fall.size();
      enable = 1'b1;
      t = 0;
      while (cnv_fall.size() <= fb && t < 200) begin step(); t++; end
      step(20);
      enable = 1'b0;
      wait_count(1, 300, "drop");
      step(400);
      check("drop_one_conversion", cnv_rise.size() - base, 1);
      check("drop_cnv_low", adc_cnv, 0);
      check("drop_sclk_low", adc_sclk, 0);
      pop_all();

      // ---- reset in ACQUIRE with three samples buffered
      for (int i = 0; i < 4; i++) model_q.push_back(DW'(16'h000A + i));
      base = cnv_rise.size(); fb = cnv_fall.size();
      enable = 1'b1;
      wait_rises(base + 4, 800, "rst");
      t = 0;
      while (cnv_fall.size() < fb + 4 && t < 100) begin step(); t++; end
      f = (cnv_fall.size() >= fb + 4) ? cnv_fall[fb + 3] : cyc;
      wait_cyc(f + 29);
      check("rst_pre_sclk", adc_sclk, 1);
      check("rst_pre_count", fifo_count, 3);
      ARESET = 1'b1; enable = 1'b0;
      step();
      check("rstmid_sclk", adc_sclk, 0);
      check("rstmid_cnv", adc_cnv, 0);
      check("rstmid_count", fifo_count, 0);
      check("rstmid_valid", rd_valid, 0);
      step(2);
      ARESET = 1'b0;
      model_q.delete();
      step(2);
      model_q.push_back(16'h00EE); exp_q.push_back(16'h00EE);
      base = cnv_rise.size();
      enable = 1'b1;
      wait_rises(base + 1, 50, "rst_re");
      enable = 1'b0;
      wait_count(1, 300, "rst_re");
      check("rst_re_data", rd_data, 16'h00EE);
      pop_all();
      check("rst_re_empty", fifo_count, 0);
      check("final_sb_empty", exp_q.size(), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_spi_capture.md
# adc_spi_capture

Upstream sample-capture stage for `adc_core`. Runs conversions on the ROIC's serial ADC at a programmed rate and shifts in each result MSB-first. Buffers samples in a small first-word-fall-through FIFO that the `adc_core` AXI4-Lite register bank pops on a read of its data register. Enable, sample period and overflow-clear come from the `adc_core` control registers; FIFO status and data go back to its status and data registers.

## Interface
- `DATA_WIDTH`, 16: ADC sample width in bits.
- `CLK_DIV`, 4: `adc_sclk` half-period in ACLK cycles; must be ≥1.
- `CONV_CYCLES`, 50: `adc_cnv` high time in ACLK cycles; must be ≥1.
- `FIFO_DEPTH`, 8: sample FIFO depth; power of two.
- `ACLK`  in  1  system clock. One clock; reset is synchronous and active-high.
- `ARESET`  in  1  synchronous, active-high reset.
- `enable`  in  1  run conversions while high.
- `sample_period`  in  16  conversion start-to-start interval in ACLK cycles.
- `clear_ovf`  in  1  single-cycle pulse; clears `overflow`.
- `adc_cnv`  out  1  conversion start to the ADC.
- `adc_sclk`  out  1  serial clock to the ADC; idles low.
- `adc_sdo`  in  1  serial data from the ADC.
- `rd_en`  in  1  pop request; ignored when `rd_valid` is low.
- `rd_data`  out  DATA_WIDTH  FIFO head.
- `rd_valid`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupancy.
- `overflow`  out  1  sticky: at least one sample was dropped.

## Operation
- FSM states: IDLE, CONVERT, ACQUIRE, STORE, WAIT.
- IDLE: leave when `enable` = 1, entering CONVERT on the next cycle.
- CONVERT: `adc_cnv` = 1 for exactly CONV_CYCLES cycles, then go to ACQUIRE. Entering CONVERT reloads the period counter.
- ACQUIRE:
  - `adc_cnv` = 0. `adc_sclk` starts low and toggles every CLK_DIV cycles, giving DATA_WIDTH full periods (2·CLK_DIV·DATA_WIDTH cycles).
  - `adc_sdo` is sampled in the ACLK cycle in which `adc_sclk` goes 0→1, and shifted into the LSB. The first sampled bit ends up as the MSB.
  - After the last falling edge, go to STORE.
- STORE: one cycle that pushes the shift register into the FIFO.
- WAIT: hold until the period counter expires, then:
  - `enable` = 1 → CONVERT;
  - `enable` = 0 → IDLE.
- Effective period = max(`sample_period`, T_MIN), where T_MIN = CONV_CYCLES + 2·CLK_DIV·DATA_WIDTH + 1 (179 at defaults). `sample_period` = 0 means T_MIN. The value is sampled on entry to CONVERT.
- `enable` falling mid-conversion: finish the current sample through STORE, then IDLE. A conversion is never truncated.
- FIFO full:
  - A push with no pop in the same cycle is dropped and sets `overflow`.
  - A push with a pop in the same cycle is accepted; count is unchanged and no overflow.
- FIFO empty: `rd_en` has no effect; `rd_data` holds its last value.
- `clear_ovf` in the same cycle as a new overflow: overflow wins, so `overflow` stays 1.
- Pointers are wrap-around modulo FIFO_DEPTH; the count distinguishes full from empty.

## Timing
- Reset values:
  - state = IDLE;
  - `adc_cnv` = 0, `adc_sclk` = 0;
  - `rd_data` = 0, `rd_valid` = 0, `fifo_count` = 0, `overflow` = 0;
  - shift register and pointers = 0.
- `ARESET` mid-operation: all of the above are forced on the next edge, the FIFO contents are discarded, and no partial sample is pushed.
- `enable` rising at edge N → `adc_cnv` = 1 from cycle N+1.
- `rd_valid` rises the cycle after STORE, i.e. T_MIN cycles after the first `adc_cnv` high cycle (179 at defaults).
- Pop: `rd_en` & `rd_valid` at edge N → next entry on `rd_data` and decremented `fifo_count` at N+1.
- All outputs are registered. `adc_sdo` is sampled directly; the ADC is treated as synchronous to ACLK.

## Configuration
- `ADC_CAPTURE_TEST_PATTERN_EN` defined:
  - `adc_sdo` is ignored.
  - STORE pushes an internal DATA_WIDTH-bit ramp counter instead of the shift register. The ramp starts at 0 after reset and increments after each push, including dropped pushes.
  - The ADC pins still toggle normally.
- Macro undefined: the shift register is pushed, and no ramp logic is present.

## Test plan
- Basic capture: defaults, model drives 0xA5C3 MSB-first, `enable` = 1, `sample_period` = 0. Required:
  - 16 `adc_sclk` rising edges after a 50-cycle `adc_cnv` pulse;
  - `rd_valid` 179 cycles after `adc_cnv` first rises;
  - `rd_data` = 0xA5C3, `fifo_count` = 1.
- Rate and continuous run: `sample_period` = 300, model returns 0x0001, 0x0002, 0x0003. Required: `adc_cnv` rising edges exactly 300 cycles apart, and three pops return 1, 2, 3 in order.
- Overflow:
  - No pops for 10 samples → `fifo_count` = 8, `overflow` = 1, and the FIFO holds the first 8 samples.
  - `clear_ovf` pulse → `overflow` = 0.
  - Pop in the same cycle as a push into a full FIFO → count stays 8 and `overflow` is not set.
- Enable drop: deassert `enable` during ACQUIRE. Required: the sample completes and is stored, `adc_cnv` stays low afterwards, and the FSM returns to IDLE.
- Reset mid-operation: assert `ARESET` during ACQUIRE with 3 samples buffered. Required: on the next edge `adc_sclk` = 0, `adc_cnv` = 0, `fifo_count` = 0, `rd_valid` = 0, and no stale sample appears after re-enable.
- Test pattern: with `ADC_CAPTURE_TEST_PATTERN_EN` defined and `adc_sdo` tied to 1, four pops return 0x0000, 0x0001, 0x0002, 0x0003.
